// File: rtl/pulse_arbiter.sv
// Round-robin arbiter that turns rising edges on N_CH request lines into
// fixed-width pulses on one shared output, tagged with the owning channel.
module pulse_arbiter #(
    parameter int N_CH        = 4,
    parameter int PULSE_WIDTH = 1,
    parameter int GAP         = 1,
    localparam int CH_W       = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic            clock,
    input  logic            reset,
    input  logic [N_CH-1:0] sig,
    output logic            pulse,
    output logic [CH_W-1:0] pulse_ch,
    output logic            busy,
    output logic [N_CH-1:0] pending,
    output logic [N_CH-1:0] drop
);

    localparam int CNT_MAX = (PULSE_WIDTH > GAP) ? PULSE_WIDTH : GAP;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX + 1) : 1;
    localparam logic [CNT_W-1:0] PULSE_LOAD = CNT_W'(PULSE_WIDTH - 1);
    localparam logic [CNT_W-1:0] GAP_LOAD   = CNT_W'((GAP > 0) ? GAP - 1 : 0);

    typedef enum logic [1:0] {
        S_IDLE,
        S_PULSE,
        S_GAP
    } state_t;

    state_t            state;
    state_t            state_n;
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  cnt_n;
    logic [N_CH-1:0]   sig_q;
    logic [N_CH-1:0]   sig_edge;
    logic [N_CH-1:0]   grant_mask;
    logic [CH_W-1:0]   last;
    logic [CH_W-1:0]   grant_idx;
    logic              grant_any;
    logic              grant_en;

    assign sig_edge = sig & ~sig_q;

    // Search starts one past the last winner so every channel gets a turn.
    always_comb begin
        grant_any = 1'b0;
        grant_idx = '0;
        for (int k = 1; k <= N_CH; k++) begin
            if (!grant_any && pending[(int'(last) + k) % N_CH]) begin
                grant_any = 1'b1;
                grant_idx = CH_W'((int'(last) + k) % N_CH);
            end
        end
    end

    always_comb begin
        for (int i = 0; i < N_CH; i++) begin
            grant_mask[i] = grant_en && (grant_idx == CH_W'(i));
        end
    end

    // A re-request that coincides with its own grant is kept, not dropped.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sig_q   <= '0;
            pending <= '0;
            drop    <= '0;
        end else begin
            sig_q   <= sig;
            pending <= (pending & ~grant_mask) | sig_edge;
            drop    <= sig_edge & pending & ~grant_mask;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state    <= S_IDLE;
            cnt      <= '0;
            last     <= CH_W'(N_CH - 1);
            pulse_ch <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            if (grant_en) begin
                last     <= grant_idx;
                pulse_ch <= grant_idx;
            end
        end
    end

    always_comb begin
        state_n  = state;
        cnt_n    = cnt;
        grant_en = 1'b0;
        case (state)
            S_IDLE: begin
                if (grant_any) begin
                    grant_en = 1'b1;
                    state_n  = S_PULSE;
                    cnt_n    = PULSE_LOAD;
                end
            end
            S_PULSE: begin
                if (cnt != '0) begin
                    cnt_n = cnt - CNT_W'(1);
                end else if (GAP > 0) begin
                    state_n = S_GAP;
                    cnt_n   = GAP_LOAD;
                end else if (grant_any) begin
                    grant_en = 1'b1;
                    cnt_n    = PULSE_LOAD;
                end else begin
                    state_n = S_IDLE;
                end
            end
            S_GAP: begin
                if (cnt != '0) begin
                    cnt_n = cnt - CNT_W'(1);
                end else if (grant_any) begin
                    grant_en = 1'b1;
                    state_n  = S_PULSE;
                    cnt_n    = PULSE_LOAD;
                end else begin
                    state_n = S_IDLE;
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    always_comb begin
        pulse = (state == S_PULSE);
        busy  = (state != S_IDLE);
    end

endmodule
